// File: rtl/freq_duty_meter.sv
// Gate-window frequency and duty-cycle meter: freq_valid at T+1, duty_valid at T+DIV_BITS+1.
// Results are one-cycle pulses with no backpressure; data holds between pulses.
module freq_duty_meter #(
   parameter logic [31:0] GATE_CYCLES = 32'd100000000,
   parameter int unsigned DIV_BITS    = 48
) (
   input  logic        freq_source,
   input  logic        rst_n,
   input  logic        sig_in,
   output logic [31:0] freq_data,
   output logic        freq_valid,
   output logic [15:0] duty_data,
   output logic        duty_valid,
   output logic        edge_sat
);
   localparam int unsigned SW = $clog2(DIV_BITS);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   logic                s1_q, s2_q, s3_q;
   logic [31:0]         gate_cnt_q, edge_cnt_q, high_cnt_q, freq_data_q;
   logic                sat_q, edge_sat_q, freq_valid_q;
   logic [31:0]         rem_q, rem_d;
   logic [DIV_BITS-1:0] num_q, num_d;
   logic [SW-1:0]       step_q, step_d;
   logic [15:0]         duty_q, duty_d;
   state_t              state_q, state_d;

   logic                gate_end, rise, edge_inc, sat_nxt;
   logic [31:0]         edge_nxt, high_tot;
   logic [32:0]         trial;

   assign rise     = s2_q & ~s3_q;
   assign gate_end = (gate_cnt_q == GATE_CYCLES - 32'd1);
   assign edge_inc = rise & (edge_cnt_q != 32'hFFFF_FFFF);
   assign edge_nxt = edge_cnt_q + {31'd0, edge_inc};
   assign sat_nxt  = sat_q | (edge_nxt == 32'hFFFF_FFFF);
   // Totals include the gate-end cycle's own contribution.
   assign high_tot = high_cnt_q + {31'd0, s2_q};

   always_ff @(posedge freq_source or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         high_cnt_q   <= '0;
         sat_q        <= 1'b0;
         freq_data_q  <= '0;
         freq_valid_q <= 1'b0;
         edge_sat_q   <= 1'b0;
         state_q      <= IDLE;
         num_q        <= '0;
         rem_q        <= '0;
         step_q       <= '0;
         duty_q       <= '0;
      end else begin
         s1_q         <= sig_in;
         s2_q         <= s1_q;
         s3_q         <= s2_q;
         freq_valid_q <= gate_end;
         if (gate_end) begin
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            high_cnt_q  <= '0;
            sat_q       <= 1'b0;
            freq_data_q <= edge_nxt;
            edge_sat_q  <= sat_nxt;
         end else begin
            gate_cnt_q  <= gate_cnt_q + 32'd1;
            edge_cnt_q  <= edge_nxt;
            high_cnt_q  <= high_tot;
            sat_q       <= sat_nxt;
         end
         state_q <= state_d;
         num_q   <= num_d;
         rem_q   <= rem_d;
         step_q  <= step_d;
         duty_q  <= duty_d;
      end
   end

   // Restoring divider: quotient bits shift into num_q as numerator bits shift out.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      rem_d      = rem_q;
      step_d     = step_q;
      duty_d     = duty_q;
      duty_valid = 1'b0;
      trial      = {rem_q, num_q[DIV_BITS-1]};
      case (state_q)
         DIV: begin
            if (trial >= {1'b0, GATE_CYCLES}) begin
               rem_d = trial[31:0] - GATE_CYCLES;
               num_d = {num_q[DIV_BITS-2:0], 1'b1};
            end else begin
               rem_d = trial[31:0];
               num_d = {num_q[DIV_BITS-2:0], 1'b0};
            end
            step_d = step_q - SW'(1);
            if (step_q == '0) begin
               state_d = DONE;
               duty_d  = (num_d > DIV_BITS'(10000)) ? 16'd10000 : num_d[15:0];
            end
         end
         DONE: begin
            duty_valid = 1'b1;
            state_d    = IDLE;
         end
         default: ;
      endcase
      // A new gate always (re)starts the divider; a stale divide is dropped.
      if (gate_end) begin
         state_d = DIV;
         num_d   = DIV_BITS'(high_tot) * DIV_BITS'(10000);
         rem_d   = '0;
         step_d  = SW'(DIV_BITS - 1);
      end
   end

   assign freq_data  = freq_data_q;
   assign freq_valid = freq_valid_q;
   assign duty_data  = duty_q;
   assign edge_sat   = edge_sat_q;

endmodule

// File: tb/tb_freq_duty_meter.sv
// Directed bench for freq_duty_meter: three instances (gates of 1000, 64 and 100 cycles).
module tb_freq_duty_meter;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig_a = 1'b0, sig_b = 1'b0, sig_c = 1'b0;
   logic [31:0] fd_a, fd_b, fd_c;
   logic [15:0] dd_a, dd_b, dd_c;
   logic        fv_a, fv_b, fv_c, dv_a, dv_b, dv_c, sat_a, sat_b, sat_c;

   always #5 clk = ~clk;

   freq_duty_meter #(.GATE_CYCLES(32'd1000), .DIV_BITS(48)) u_a (
      .freq_source(clk), .rst_n(rst_n), .sig_in(sig_a), .freq_data(fd_a), .freq_valid(fv_a),
      .duty_data(dd_a), .duty_valid(dv_a), .edge_sat(sat_a));
   freq_duty_meter #(.GATE_CYCLES(32'd64), .DIV_BITS(48)) u_b (
      .freq_source(clk), .rst_n(rst_n), .sig_in(sig_b), .freq_data(fd_b), .freq_valid(fv_b),
      .duty_data(dd_b), .duty_valid(dv_b), .edge_sat(sat_b));
   freq_duty_meter #(.GATE_CYCLES(32'd100), .DIV_BITS(48)) u_c (
      .freq_source(clk), .rst_n(rst_n), .sig_in(sig_c), .freq_data(fd_c), .freq_valid(fv_c),
      .duty_data(dd_c), .duty_valid(dv_c), .edge_sat(sat_c));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int rst_cyc = 0;
   int coinc = 0;
   bit sig_hist [0:19999];
   int fa_t[$], fa_d[$], fa_s[$], da_t[$], da_d[$];
   int fb_t[$], fb_d[$], fc_t[$], fc_d[$], dc_t[$], dc_d[$];

   // Advance one cycle; record the sig_a value held during the cycle just left, then log pulses.
   task automatic tick();
      if (cyc < 20000) sig_hist[cyc] = sig_a;
      @(negedge clk);
      cyc++;
      if (fv_a) begin fa_t.push_back(cyc); fa_d.push_back(int'(fd_a)); fa_s.push_back(int'(sat_a)); end
      if (dv_a) begin da_t.push_back(cyc); da_d.push_back(int'(dd_a)); end
      if (fv_b) begin fb_t.push_back(cyc); fb_d.push_back(int'(fd_b)); end
      if (fv_c) begin fc_t.push_back(cyc); fc_d.push_back(int'(fd_c)); end
      if (dv_c) begin dc_t.push_back(cyc); dc_d.push_back(int'(dd_c)); end
      if ((fv_a && dv_a) || (fv_b && dv_b) || (fv_c && dv_c)) coinc++;
   endtask

   task automatic clear_q();
      fa_t.delete(); fa_d.delete(); fa_s.delete(); da_t.delete(); da_d.delete();
      fb_t.delete(); fb_d.delete(); fc_t.delete(); fc_d.delete(); dc_t.delete(); dc_d.delete();
   endtask

   // Reference synchronizer output: sig_in delayed two clocks, zero until refilled after reset.
   function automatic int s2m(int k);
      if (k < rst_cyc + 2 || k - 2 > 19999) return 0;
      return int'(sig_hist[k-2]);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_chk++; if (fd_a !== 32'd0) begin n_fail++; $display("FAIL reset_freq_data: got %0d expected 0", fd_a); end
      n_chk++; if (dd_a !== 16'd0) begin n_fail++; $display("FAIL reset_duty_data: got %0d expected 0", dd_a); end
      n_chk++; if (fv_a !== 1'b0 || dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b expected 00", fv_a, dv_a); end
      n_chk++; if (sat_a !== 1'b0) begin n_fail++; $display("FAIL reset_edge_sat: got %b expected 0", sat_a); end
      n_chk++; if ((fd_b | fd_c) !== 32'd0 || (dd_b | dd_c) !== 16'd0 || (sat_b | sat_c) !== 1'b0) begin
         n_fail++; $display("FAIL reset_other_inst: got %0d/%0d/%b expected 0/0/0", fd_b | fd_c, dd_b | dd_c, sat_b | sat_c); end
      rst_n   = 1'b1;
      rst_cyc = cyc;
   endtask

   task automatic test_aligned();
      clear_q();
      for (int i = 0; i < 2100; i++) begin tick(); sig_a = ((cyc % 10) < 3); end
      n_chk++; if (fa_t.size() != 2 || da_t.size() != 2) begin
         n_fail++; $display("FAIL aligned_pulse_count: got %0d/%0d expected 2/2", fa_t.size(), da_t.size());
      end else begin
         n_chk++; if (fa_t[0] != rst_cyc + 1000) begin n_fail++; $display("FAIL aligned_first_pulse: got %0d expected %0d", fa_t[0], rst_cyc + 1000); end
         n_chk++; if (fa_d[1] != 100) begin n_fail++; $display("FAIL aligned_freq: got %0d expected 100", fa_d[1]); end
         n_chk++; if (da_d[1] != 3000) begin n_fail++; $display("FAIL aligned_duty: got %0d expected 3000", da_d[1]); end
         n_chk++; if (da_t[1] - fa_t[1] != 48) begin n_fail++; $display("FAIL aligned_duty_latency: got %0d expected 48", da_t[1] - fa_t[1]); end
         n_chk++; if (fa_s[1] != 0) begin n_fail++; $display("FAIL aligned_edge_sat: got %0d expected 0", fa_s[1]); end
      end
   endtask

   task automatic test_const();
      int mx;
      mx = 0;
      clear_q();
      for (int i = 0; i < 1950; i++) begin tick(); sig_a = 1'b1; end
      foreach (da_d[i]) if (da_d[i] > mx) mx = da_d[i];
      n_chk++; if (fa_t.size() != 2 || da_t.size() != 2) begin
         n_fail++; $display("FAIL high_pulse_count: got %0d/%0d expected 2/2", fa_t.size(), da_t.size());
      end else begin
         n_chk++; if (fa_d[1] != 0) begin n_fail++; $display("FAIL high_freq: got %0d expected 0", fa_d[1]); end
         n_chk++; if (da_d[1] != 10000) begin n_fail++; $display("FAIL high_duty: got %0d expected 10000", da_d[1]); end
      end
      clear_q();
      for (int i = 0; i < 2000; i++) begin tick(); sig_a = 1'b0; end
      foreach (da_d[i]) if (da_d[i] > mx) mx = da_d[i];
      n_chk++; if (fa_t.size() != 2 || da_t.size() != 2) begin
         n_fail++; $display("FAIL low_pulse_count: got %0d/%0d expected 2/2", fa_t.size(), da_t.size());
      end else begin
         n_chk++; if (fa_d[1] != 0) begin n_fail++; $display("FAIL low_freq: got %0d expected 0", fa_d[1]); end
         n_chk++; if (da_d[1] != 0) begin n_fail++; $display("FAIL low_duty: got %0d expected 0", da_d[1]); end
      end
      n_chk++; if (mx > 10000) begin n_fail++; $display("FAIL duty_clamp: got max %0d expected <= 10000", mx); end
   endtask

   task automatic test_unaligned();
      int p, edges, high;
      clear_q();
      for (int i = 0; i < 2050; i++) begin tick(); sig_a = (((cyc + 3) % 7) < 2); end
      n_chk++; if (fa_t.size() != 2 || da_t.size() != 2) begin
         n_fail++; $display("FAIL unal_pulse_count: got %0d/%0d expected 2/2", fa_t.size(), da_t.size());
      end else begin
         p = fa_t[1]; edges = 0; high = 0;
         for (int k = p - 1000; k < p; k++) begin
            high += s2m(k);
            if (s2m(k) == 1 && s2m(k - 1) == 0) edges++;
         end
         n_chk++; if (fa_d[1] != edges) begin n_fail++; $display("FAIL unal_freq_model: got %0d expected %0d", fa_d[1], edges); end
         n_chk++; if (da_d[1] != high * 10) begin n_fail++; $display("FAIL unal_duty_model: got %0d expected %0d", da_d[1], high * 10); end
         n_chk++; if (fa_d[1] < 142 || fa_d[1] > 143) begin n_fail++; $display("FAIL unal_freq_range: got %0d expected 142..143", fa_d[1]); end
         n_chk++; if (da_d[1] < 2840 || da_d[1] > 2880) begin n_fail++; $display("FAIL unal_duty_range: got %0d expected 2840..2880", da_d[1]); end
      end
   endtask

   task automatic test_gate_edge();
      int t, t2, v1, v2, v3, mx;
      t = rst_cyc + 63;
      while (t < cyc + 4) t += 64;
      t2 = t + 64;
      v1 = -1; v2 = -1; v3 = -1; mx = 0;
      clear_q();
      while (cyc < t2 + 68) begin
         tick();
         sig_b = (cyc == t - 2) || (cyc == t2 - 1);
      end
      foreach (fb_t[i]) begin
         if (fb_t[i] == t + 1)  v1 = fb_d[i];
         if (fb_t[i] == t2 + 1) v2 = fb_d[i];
         if (fb_t[i] == t2 + 65) v3 = fb_d[i];
         if (fb_d[i] > mx) mx = fb_d[i];
      end
      n_chk++; if (v1 != 1) begin n_fail++; $display("FAIL edge_on_T: got %0d expected 1", v1); end
      n_chk++; if (v2 != 0) begin n_fail++; $display("FAIL edge_gap_gate: got %0d expected 0", v2); end
      n_chk++; if (v3 != 1) begin n_fail++; $display("FAIL edge_on_T_plus_1: got %0d expected 1", v3); end
      n_chk++; if (mx > 1) begin n_fail++; $display("FAIL edge_double_count: got %0d expected <= 1", mx); end
   endtask

   task automatic test_reset_div();
      int t, edges, high;
      t = rst_cyc + 999;
      while (t < cyc + 2) t += 1000;
      while (cyc < t + 10) begin tick(); sig_a = ((cyc % 10) < 3); end
      clear_q();
      rst_n = 1'b0;
      repeat (2) begin tick(); sig_a = ((cyc % 10) < 3); end
      n_chk++; if (fd_a !== 32'd0 || dd_a !== 16'd0) begin n_fail++; $display("FAIL middiv_reset_data: got %0d/%0d expected 0/0", fd_a, dd_a); end
      n_chk++; if (fv_a !== 1'b0 || dv_a !== 1'b0 || sat_a !== 1'b0) begin n_fail++; $display("FAIL middiv_reset_flags: got %b%b%b expected 000", fv_a, dv_a, sat_a); end
      rst_n   = 1'b1;
      rst_cyc = cyc;
      for (int i = 0; i < 2050; i++) begin tick(); sig_a = ((cyc % 10) < 3); end
      n_chk++; if (fa_t.size() != 2 || da_t.size() != 2) begin
         n_fail++; $display("FAIL middiv_pulse_count: got %0d/%0d expected 2/2", fa_t.size(), da_t.size());
      end else begin
         edges = 0; high = 0;
         for (int k = rst_cyc; k < rst_cyc + 1000; k++) begin
            high += s2m(k);
            if (s2m(k) == 1 && s2m(k - 1) == 0) edges++;
         end
         n_chk++; if (da_t[0] != rst_cyc + 1048) begin n_fail++; $display("FAIL middiv_first_duty_time: got %0d expected %0d", da_t[0], rst_cyc + 1048); end
         n_chk++; if (fa_d[0] != edges) begin n_fail++; $display("FAIL middiv_first_freq: got %0d expected %0d", fa_d[0], edges); end
         n_chk++; if (da_d[0] != high * 10) begin n_fail++; $display("FAIL middiv_first_duty: got %0d expected %0d", da_d[0], high * 10); end
         n_chk++; if (fa_d[1] != 100 || da_d[1] != 3000) begin n_fail++; $display("FAIL middiv_second_gate: got %0d/%0d expected 100/3000", fa_d[1], da_d[1]); end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      bad = 0;
      clear_q();
      for (int i = 0; i < 450; i++) begin tick(); sig_c = ((cyc % 10) < 5); end
      n_chk++; if (fc_t.size() < 4 || dc_t.size() < 3) begin
         n_fail++; $display("FAIL b2b_pulse_count: got %0d/%0d expected >=4/>=3", fc_t.size(), dc_t.size());
      end else begin
         for (int i = 1; i < fc_t.size(); i++) begin
            n_chk++; if (fc_t[i] - fc_t[i-1] != 100) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected 100", i, fc_t[i] - fc_t[i-1]); end
         end
         foreach (dc_t[i]) begin
            int hit;
            hit = (dc_t[i] == fc_t[0] - 52) ? 1 : 0;
            foreach (fc_t[j]) if (fc_t[j] + 48 == dc_t[i]) hit = 1;
            if (i > 0 && dc_t[i] - dc_t[i-1] != 100) hit = 0;
            if (hit == 0) bad++;
         end
         n_chk++; if (bad != 0) begin n_fail++; $display("FAIL b2b_duty_timing: got %0d misplaced expected 0", bad); end
         n_chk++; if (fc_d[fc_d.size()-1] != 10) begin n_fail++; $display("FAIL b2b_freq: got %0d expected 10", fc_d[fc_d.size()-1]); end
         n_chk++; if (dc_d[dc_d.size()-1] != 5000) begin n_fail++; $display("FAIL b2b_duty: got %0d expected 5000", dc_d[dc_d.size()-1]); end
      end
      n_chk++; if (coinc != 0) begin n_fail++; $display("FAIL valid_coincide: got %0d expected 0", coinc); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_const();
      test_unaligned();
      test_gate_edge();
      test_reset_div();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/freq_duty_meter.md
Name: freq_duty_meter

Overview:
- Measures frequency and duty cycle of one external digital signal over a fixed gate window.
- Produces the `freq_data`/`freq_valid` and `duty_data`/`duty_valid` streams that the seven-segment display block consumes.
- Runs in the display's clock domain, so no CDC is needed on its outputs.
- Frequency is an edge count per gate; duty cycle is high-time/gate-time in 0.01 % units, computed by a sequential restoring divider.

Parameters:
- `GATE_CYCLES`, 100000000, gate window length in clock cycles. `freq_data` is in Hz when this equals the clock frequency. Legal range 64..2^32-1.
- `DIV_BITS`, 48, numerator width of the duty divider. Must satisfy 2^DIV_BITS > GATE_CYCLES*10000.

Ports:
- `freq_source`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `sig_in`, input, 1: asynchronous signal under measurement.
- `freq_data`, output, 32: rising-edge count of the last completed gate.
- `freq_valid`, output, 1: one-cycle pulse when `freq_data` updates.
- `duty_data`, output, 16: duty cycle of the last completed gate, 0..10000 (units 0.01 %).
- `duty_valid`, output, 1: one-cycle pulse when `duty_data` updates.
- `edge_sat`, output, 1: sticky; set when the edge counter saturated in the last gate.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `freq_data` = 0, `duty_data` = 0, `freq_valid` = 0, `duty_valid` = 0, `edge_sat` = 0.
  - Gate counter = 0, edge/high counters = 0, synchronizer = 0, FSM = IDLE.
  - Reset asserted mid-gate or mid-divide aborts the operation; no partial result is ever published.
- Input conditioning:
  - 2-FF synchronizer s1→s2, plus delayed copy s3.
  - Rising edge = s2 & ~s3; high = s2.
  - Edge-to-count latency is 3 cycles; no filtering.
- Gate counter:
  - Counts 0..GATE_CYCLES-1 and wraps.
  - Cycle T is the cycle where the counter = GATE_CYCLES-1 (gate end).
- Accumulators:
  - `edge_cnt` +1 per rising edge, saturating at 32'hFFFFFFFF; saturation sets the internal sat flag.
  - `high_cnt` +1 per cycle with s2 = 1; maximum value is GATE_CYCLES, so it cannot overflow.
- Gate boundary (cycle T):
  - The values latched include cycle T's own contribution.
  - Accumulators restart at 0, plus cycle T+1's contribution. There is no dead cycle.
- Cycle T+1:
  - `freq_data` <= latched edge count; `freq_valid` = 1 for exactly this cycle.
  - `edge_sat` <= latched sat flag.
  - Divider starts: numerator = latched high × 10000 (DIV_BITS wide), denominator = GATE_CYCLES.
- Divider FSM:
  - IDLE → DIV on gate end.
  - DIV executes one restoring step per cycle for DIV_BITS cycles (T+1..T+DIV_BITS), MSB first, truncating quotient.
  - DONE is 1 cycle at T+DIV_BITS+1: `duty_data` <= min(quotient, 10000) [15:0], `duty_valid` = 1, then → IDLE.
  - With the default parameters, `duty_valid` is asserted at T+49.
- No overlap: GATE_CYCLES ≥ 64 > DIV_BITS+2, so the divider is always IDLE at the next gate end. If ever found busy, the new gate restarts the divider and the old result is dropped.
- Output stability: `freq_valid` and `duty_valid` never pulse in the same cycle. Outputs hold between pulses.
- Boundary cases:
  - Constant-high input: freq 0, duty 10000.
  - Constant-low input: freq 0, duty 0.
  - An edge arriving synchronized exactly at cycle T counts in the closing gate.
  - The first gate after reset publishes normally (partial synchronizer fill is acceptable).

Test Plan:
- GATE_CYCLES=1000; `sig_in` period 10 cycles, 3 high, aligned to the clock → `freq_valid` pulse with `freq_data`=100; `duty_valid` 48 cycles later with `duty_data`=3000; `edge_sat`=0.
- GATE_CYCLES=1000; `sig_in` held 1, then held 0 → `freq_data`=0 / `duty_data`=10000, then `freq_data`=0 / `duty_data`=0, `duty_data` clamped and never above 10000.
- GATE_CYCLES=1000; period 7, 2 high, unaligned phase → `freq_data` ∈ {142,143}; `duty_data` = floor(high×10000/1000) with high ∈ {284..288}; values match a scoreboard computed from s2.
- GATE_CYCLES=64; single 1-cycle pulse synchronized onto cycle T, then onto T+1 → first reported in the closing gate (`freq_data`=1), second in the next gate; no gate reports both.
- Assert `rst_n` low for 2 cycles during DIV, then release → outputs 0, no `duty_valid` from the aborted divide; the next full gate reports correct values.
- GATE_CYCLES=100; check pulse widths → each `freq_valid` and `duty_valid` pulse is exactly 1 cycle; spacing between successive `freq_valid` pulses is exactly 100 cycles; the two valids never coincide.
